// File: rtl/sdr_ram_responder.sv
// sdr_ram_responder: memory-side SDRAM responder for controller benches.
// Decodes commands, tracks banks/tRCD, bursts with CL read pipe and DQM.
//
// Ports:
//   sdram_clk, sdram_resetn      clock, async active-low reset
//   sdr_cke                      clock enable (0 freezes all state)
//   sdr_cs_n/ras_n/cas_n/we_n    command pins
//   sdr_ba, sdr_addr, sdr_dqm    bank, address/mode, byte mask
//   dq_in                        sampled sdr_dq
//   dq_out, dq_oe                read data and per-byte output enable
//   err, err_code                violation pulse and its sticky cause
module sdr_ram_responder #(
  parameter int SDR_DW = 16,
  parameter int SDR_BW = 2,
  parameter int ROW_AW = 4,
  parameter int COL_AW = 8,
  parameter int T_RCD  = 2
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic              sdr_cke,
  input  logic              sdr_cs_n,
  input  logic              sdr_ras_n,
  input  logic              sdr_cas_n,
  input  logic              sdr_we_n,
  input  logic [1:0]        sdr_ba,
  input  logic [12:0]       sdr_addr,
  input  logic [SDR_BW-1:0] sdr_dqm,
  input  logic [SDR_DW-1:0] dq_in,
  output logic [SDR_DW-1:0] dq_out,
  output logic [SDR_BW-1:0] dq_oe,
  output logic              err,
  output logic [2:0]        err_code
);

  localparam int MW = 2 + ROW_AW + COL_AW;
  localparam int TW = (T_RCD > 1) ? $clog2(T_RCD) : 1;
  localparam logic [TW-1:0] TRCD_LD = TW'(T_RCD - 1);

  logic [SDR_DW-1:0] mem [2**MW];

  logic [3:0] cmd;
  logic vld, is_lmr, is_ref, is_pre, is_act;
  logic is_wr, is_rd, is_bst, lmr_ok;
  logic unused_addr;

  assign cmd    = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
  assign vld    = sdr_cke & ~sdr_cs_n;
  assign is_lmr = vld & (cmd == 4'b0000);
  assign is_ref = vld & (cmd == 4'b0001);
  assign is_pre = vld & (cmd == 4'b0010);
  assign is_act = vld & (cmd == 4'b0011);
  assign is_wr  = vld & (cmd == 4'b0100);
  assign is_rd  = vld & (cmd == 4'b0101);
  assign is_bst = vld & (cmd == 4'b0110);
  assign lmr_ok = ((sdr_addr[6:4] == 3'd2) |
                   (sdr_addr[6:4] == 3'd3)) &
                  ~sdr_addr[3] & ~sdr_addr[2];
  assign unused_addr = ^sdr_addr;

  // mode register
  logic [1:0] cl_q, bl_q;
  logic       single_q;

  // bank state
  logic [3:0]        open_q, open_d;
  logic [ROW_AW-1:0] row_q  [4];
  logic [ROW_AW-1:0] row_d  [4];
  logic [TW-1:0]     trcd_q [4];
  logic [TW-1:0]     trcd_d [4];

  // burst engine
  logic              bact_q, bact_d;
  logic              bwr_q, bwr_d;
  logic              bap_q, bap_d;
  logic [1:0]        bbank_q, bbank_d;
  logic [1:0]        blc_q, blc_d;
  logic [2:0]        beat_q, beat_d;
  logic [COL_AW-1:0] bcol_q, bcol_d;

  // read pipeline and outputs
  logic              pv1_q, pv2_q;
  logic [SDR_DW-1:0] pd1_q, pd2_q, out_q;
  logic [SDR_BW-1:0] oe_q, dqm_q;
  logic              err_q;
  logic [2:0]        err_code_q;

  logic bank_ok, rw_go, stop;
  assign bank_ok = open_q[sdr_ba];
  assign rw_go   = (is_rd | is_wr) & bank_ok;
  assign stop    = is_bst |
                   (is_pre & (sdr_addr[10] | (sdr_ba == bbank_q)));

  logic              iss, iss_wr, iss_ap, iss_last, rd_iss;
  logic [1:0]        iss_bank, iss_lc;
  logic [2:0]        iss_idx, iss_m, bmask;
  logic [COL_AW-1:0] iss_base, iss_col, lmask;
  logic [MW-1:0]     iss_addr;
  logic [SDR_DW-1:0] rdata;

  assign bmask = 3'((4'd1 << blc_q) - 4'd1);

  always_comb begin
    iss      = 1'b0;
    iss_wr   = bwr_q;
    iss_bank = bbank_q;
    iss_lc   = blc_q;
    iss_base = bcol_q;
    iss_idx  = beat_q;
    iss_ap   = bap_q;
    bact_d   = bact_q;
    bwr_d    = bwr_q;
    bap_d    = bap_q;
    bbank_d  = bbank_q;
    blc_d    = blc_q;
    beat_d   = beat_q;
    bcol_d   = bcol_q;
    if (rw_go) begin
      // a new RD/WR always replaces the running burst
      iss      = 1'b1;
      iss_wr   = is_wr;
      iss_bank = sdr_ba;
      iss_lc   = (is_wr & single_q) ? 2'd0 : bl_q;
      iss_base = sdr_addr[COL_AW-1:0];
      iss_idx  = 3'd0;
      iss_ap   = sdr_addr[10];
      bact_d   = (iss_lc != 2'd0);
      bwr_d    = is_wr;
      bap_d    = sdr_addr[10];
      bbank_d  = sdr_ba;
      blc_d    = iss_lc;
      beat_d   = 3'd1;
      bcol_d   = sdr_addr[COL_AW-1:0];
    end else if (bact_q & sdr_cke) begin
      if (stop) begin
        bact_d = 1'b0;
      end else begin
        iss    = 1'b1;
        beat_d = beat_q + 3'd1;
        if (beat_q == bmask) bact_d = 1'b0;
      end
    end
  end

  // beat column wraps inside its BL-aligned block
  assign iss_m    = 3'((4'd1 << iss_lc) - 4'd1);
  assign iss_last = (iss_idx == iss_m);
  assign lmask    = COL_AW'(iss_m);
  assign iss_col  = (iss_base & ~lmask) |
                    ((iss_base + COL_AW'(iss_idx)) & lmask);
  assign iss_addr = {iss_bank, row_q[iss_bank], iss_col};
  assign rdata    = mem[iss_addr];
  assign rd_iss   = iss & ~iss_wr;

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    trcd_d = trcd_q;
    for (int b = 0; b < 4; b++) begin
      if (trcd_q[b] != '0) trcd_d[b] = trcd_q[b] - TW'(1);
      if (iss & iss_last & iss_ap & (iss_bank == 2'(b)))
        open_d[b] = 1'b0;
      if (is_pre & (sdr_addr[10] | (sdr_ba == 2'(b))))
        open_d[b] = 1'b0;
      if (is_act & ~open_q[b] & (sdr_ba == 2'(b))) begin
        open_d[b] = 1'b1;
        row_d[b]  = sdr_addr[ROW_AW-1:0];
        trcd_d[b] = TRCD_LD;
      end
    end
  end

  logic       e_hit;
  logic [2:0] e_code;

  always_comb begin
    e_hit  = 1'b1;
    e_code = 3'd0;
    unique case (1'b1)
      is_act & bank_ok:              e_code = 3'd1;
      (is_rd | is_wr) & ~bank_ok:    e_code = 3'd2;
      is_ref & (|open_q):            e_code = 3'd3;
      is_lmr & ~lmr_ok:              e_code = 3'd4;
      rw_go & (trcd_q[sdr_ba] != '0): e_code = 3'd5;
      default:                       e_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      cl_q     <= 2'd3;
      bl_q     <= 2'd0;
      single_q <= 1'b0;
      open_q   <= '0;
      for (int b = 0; b < 4; b++) begin
        row_q[b]  <= '0;
        trcd_q[b] <= '0;
      end
      bact_q  <= 1'b0;
      bwr_q   <= 1'b0;
      bap_q   <= 1'b0;
      bbank_q <= '0;
      blc_q   <= '0;
      beat_q  <= '0;
      bcol_q  <= '0;
    end else if (sdr_cke) begin
      if (is_lmr & lmr_ok) begin
        cl_q     <= sdr_addr[5:4];
        bl_q     <= sdr_addr[1:0];
        single_q <= sdr_addr[9];
      end
      open_q  <= open_d;
      row_q   <= row_d;
      trcd_q  <= trcd_d;
      bact_q  <= bact_d;
      bwr_q   <= bwr_d;
      bap_q   <= bap_d;
      bbank_q <= bbank_d;
      blc_q   <= blc_d;
      beat_q  <= beat_d;
      bcol_q  <= bcol_d;
    end
  end

  // CL=3 beats enter stage 1, CL=2 beats skip straight to stage 2
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      pv1_q      <= 1'b0;
      pv2_q      <= 1'b0;
      pd1_q      <= '0;
      pd2_q      <= '0;
      out_q      <= '0;
      oe_q       <= '0;
      dqm_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
    end else if (sdr_cke) begin
      err_q <= e_hit;
      if (e_hit) err_code_q <= e_code;
      dqm_q <= sdr_dqm;
      if (is_wr) begin
        pv1_q <= 1'b0;
        pv2_q <= 1'b0;
        oe_q  <= '0;
      end else begin
        pv1_q <= rd_iss & (cl_q == 2'd3);
        pd1_q <= rdata;
        pv2_q <= (rd_iss & (cl_q == 2'd2)) | pv1_q;
        pd2_q <= (rd_iss & (cl_q == 2'd2)) ? rdata : pd1_q;
        oe_q  <= pv2_q ? ~dqm_q : '0;
        if (pv2_q) out_q <= pd2_q;
      end
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (iss & iss_wr) begin
      for (int j = 0; j < SDR_BW; j++) begin
        if (!sdr_dqm[j])
          mem[iss_addr][8*j +: 8] <= dq_in[8*j +: 8];
      end
    end
  end

  // the controller owns the bus in a WR cycle
  assign dq_oe    = oe_q & {SDR_BW{~is_wr}};
  assign dq_out   = out_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule
